// File: rtl/fifo_port_arb.sv
// ============================================================================
// Module   : fifo_port_arb
// Brief    : Round-robin arbiter in front of a single-port 8-deep FIFO with two
//            writers and one reader, guarded by a shadow occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_port_arb #(
    parameter int DEPTH = 8,
    parameter int DW    = 32,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_wr0,
    input  logic [DW-1:0] din0,
    input  logic          req_wr1,
    input  logic [DW-1:0] din1,
    input  logic          req_rd,
    output logic          gnt_wr0,
    output logic          gnt_wr1,
    output logic          gnt_rd,
    output logic          wr_en,
    output logic          rd_en,
    output logic [DW-1:0] fifo_din,
    input  logic          fifo_wr_err,
    input  logic          fifo_rd_err,
    input  logic          clr_halt,
    output logic [CW-1:0] occ,
    output logic          halted
);

    localparam logic [1:0]    C_LS_W0 = 2'd0;
    localparam logic [1:0]    C_LS_W1 = 2'd1;
    localparam logic [1:0]    C_LS_R  = 2'd2;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [1:0]    last_q, last_d;

    logic w_el_w0, w_el_w1, w_el_r;
    logic w_g0, w_g1, w_gr;

    always_comb begin
        w_el_w0 = req_wr0 && (occ_q < C_DEPTH);
        w_el_w1 = req_wr1 && (occ_q < C_DEPTH);
        w_el_r  = req_rd  && (occ_q != '0);
        w_g0    = 1'b0;
        w_g1    = 1'b0;
        w_gr    = 1'b0;

        // Search starts at the requester after the last one served.
        if ((state_q == ST_RUN) && !reset) begin
            case (last_q)
                C_LS_W0: begin
                    if      (w_el_w1) w_g1 = 1'b1;
                    else if (w_el_r)  w_gr = 1'b1;
                    else if (w_el_w0) w_g0 = 1'b1;
                end
                C_LS_W1: begin
                    if      (w_el_r)  w_gr = 1'b1;
                    else if (w_el_w0) w_g0 = 1'b1;
                    else if (w_el_w1) w_g1 = 1'b1;
                end
                default: begin
                    if      (w_el_w0) w_g0 = 1'b1;
                    else if (w_el_w1) w_g1 = 1'b1;
                    else if (w_el_r)  w_gr = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        occ_d   = occ_q;
        last_d  = last_q;

        case (state_q)
            ST_RUN:  if (fifo_wr_err || fifo_rd_err) state_d = ST_HALT;
            ST_HALT: if (clr_halt && !fifo_wr_err && !fifo_rd_err) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase

        if (w_g0 || w_g1) begin
            occ_d = occ_q + C_ONE;
        end else if (w_gr) begin
            occ_d = occ_q - C_ONE;
        end

        if (w_g0)      last_d = C_LS_W0;
        else if (w_g1) last_d = C_LS_W1;
        else if (w_gr) last_d = C_LS_R;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            occ_q   <= '0;
            last_q  <= C_LS_R;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            last_q  <= last_d;
        end
    end

    assign gnt_wr0  = w_g0;
    assign gnt_wr1  = w_g1;
    assign gnt_rd   = w_gr;
    assign wr_en    = w_g0 | w_g1;
    assign rd_en    = w_gr;
    assign fifo_din = w_g0 ? din0 : (w_g1 ? din1 : '0);
    assign occ      = occ_q;
    assign halted   = (state_q == ST_HALT);

endmodule

`default_nettype wire
